// File: rtl/cluster_expander_if.sv
// rtl/cluster_expander_if.sv - slot input and strip-map output bundle for cluster_expander (optional CLUSTER_EXPANDER_BADADR_CNT_EN adds bad_adr_cnt)
interface cluster_expander_if #(
  parameter int MXSTRIPS = 1536
);
  logic                slot_valid;
  logic                sof;
  logic                vpf_in;
  logic [10:0]         adr_in;
  logic [2:0]          cnt_in;
  logic [MXSTRIPS-1:0] vpfs_out;
  logic [3:0]          ncl_out;
  logic                latch_out;
  logic                abort_out;
`ifdef CLUSTER_EXPANDER_BADADR_CNT_EN
  logic [7:0]          bad_adr_cnt;
`endif

  // Slot source side: presents slots, observes the reconstructed frame
  modport master (
`ifdef CLUSTER_EXPANDER_BADADR_CNT_EN
    input  bad_adr_cnt,
`endif
    output slot_valid, sof, vpf_in, adr_in, cnt_in,
    input  vpfs_out, ncl_out, latch_out, abort_out
  );

  // Expander side: consumes slots, produces the reconstructed frame
  modport slave (
`ifdef CLUSTER_EXPANDER_BADADR_CNT_EN
    output bad_adr_cnt,
`endif
    input  slot_valid, sof, vpf_in, adr_in, cnt_in,
    output vpfs_out, ncl_out, latch_out, abort_out
  );
endinterface

// File: rtl/cluster_expander.sv
// rtl/cluster_expander.sv - rebuilds a strip hit map from per-frame cluster slots (optional CLUSTER_EXPANDER_BADADR_CNT_EN: bad address counter)
module cluster_expander #(
  parameter int MXCLUSTERS = 8,
  parameter int MXSTRIPS   = 1536
) (
  input  logic               clock,
  input  logic               reset,
  cluster_expander_if.slave  bus
);

  localparam int CW = (MXCLUSTERS > 1) ? $clog2(MXCLUSTERS) : 1;
  localparam logic [CW-1:0] LAST_SLOT = CW'(MXCLUSTERS - 1);

  typedef enum logic {IDLE, COLLECT} state_t;

  state_t              state, state_nxt;
  logic [CW-1:0]       slot_cnt, slot_cnt_nxt, slot_idx;
  logic [MXSTRIPS-1:0] acc, acc_nxt, acc_base, run_mask;
  logic [3:0]          ncl_acc, ncl_nxt, ncl_base;
  logic [7:0]          run8;
  logic                accept, adr_ok, hit, do_latch, do_abort;

  // Cluster footprint: cnt_in+1 ones starting at adr_in; the shift drops anything past the last strip
  always_comb begin
    run8     = 8'hff >> (3'd7 - bus.cnt_in);
    run_mask = {{(MXSTRIPS-8){1'b0}}, run8} << bus.adr_in;
    adr_ok   = 32'(bus.adr_in) < MXSTRIPS;
    hit      = bus.vpf_in && adr_ok;
  end

  // Next-state and frame bookkeeping; sof always restarts at slot 0 with a clean accumulator
  always_comb begin
    state_nxt    = state;
    slot_cnt_nxt = slot_cnt;
    acc_nxt      = acc;
    ncl_nxt      = ncl_acc;
    do_latch     = 1'b0;
    do_abort     = 1'b0;
    accept       = bus.slot_valid && (bus.sof || (state == COLLECT));
    slot_idx     = bus.sof ? '0 : slot_cnt;
    acc_base     = bus.sof ? '0 : acc;
    ncl_base     = bus.sof ? 4'd0 : ncl_acc;
    if (accept) begin
      do_abort = bus.sof && (state == COLLECT);
      acc_nxt  = acc_base | (hit ? run_mask : '0);
      ncl_nxt  = ncl_base + {3'd0, hit};
      if (slot_idx == LAST_SLOT) begin
        state_nxt    = IDLE;
        slot_cnt_nxt = '0;
        do_latch     = 1'b1;
      end else begin
        state_nxt    = COLLECT;
        slot_cnt_nxt = slot_idx + 1'b1;
      end
    end
  end

  // State register
  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Frame accumulator and slot counter
  always_ff @(posedge clock) begin
    if (reset) begin
      slot_cnt <= '0;
      acc      <= '0;
      ncl_acc  <= '0;
    end else begin
      slot_cnt <= slot_cnt_nxt;
      acc      <= acc_nxt;
      ncl_acc  <= ncl_nxt;
    end
  end

  // Published results change only on latch; pulses last exactly one cycle
  always_ff @(posedge clock) begin
    if (reset) begin
      bus.vpfs_out  <= '0;
      bus.ncl_out   <= '0;
      bus.latch_out <= 1'b0;
      bus.abort_out <= 1'b0;
    end else begin
      bus.latch_out <= do_latch;
      bus.abort_out <= do_abort;
      if (do_latch) begin
        bus.vpfs_out <= acc_nxt;
        bus.ncl_out  <= ncl_nxt;
      end
    end
  end

`ifdef CLUSTER_EXPANDER_BADADR_CNT_EN
  // Saturating count of processed valid slots whose address lies off the strip map
  always_ff @(posedge clock) begin
    if (reset)
      bus.bad_adr_cnt <= '0;
    else if (accept && bus.vpf_in && !adr_ok && (bus.bad_adr_cnt != 8'hff))
      bus.bad_adr_cnt <= bus.bad_adr_cnt + 8'd1;
  end
`endif

endmodule

// File: doc/cluster_expander.md
CLUSTER_EXPANDER -- requirements
Module: cluster_expander

Interface
REQ-001 SHALL have parameter MXCLUSTERS, default 8, meaning cluster slots per frame.
REQ-002 SHALL have parameter MXSTRIPS, default 1536, meaning width of the reconstructed strip map.
REQ-003 SHALL have port clock  in  1  single clock for all logic.
REQ-004 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-005 SHALL have port slot_valid  in  1  qualifies the slot fields this cycle.
REQ-006 SHALL have port sof  in  1  start of frame, sampled only with slot_valid; marks slot 0.
REQ-007 SHALL have port vpf_in  in  1  slot holds a valid cluster.
REQ-008 SHALL have port adr_in  in  11  first strip address of the cluster.
REQ-009 SHALL have port cnt_in  in  3  cluster size minus one.
REQ-010 SHALL have port vpfs_out  out  MXSTRIPS  reconstructed strip hit map.
REQ-011 SHALL have port ncl_out  out  4  number of valid clusters accepted in the frame.
REQ-012 SHALL have port latch_out  out  1  one-cycle pulse when vpfs_out/ncl_out update.
REQ-013 SHALL have port abort_out  out  1  one-cycle pulse when a frame is discarded.

Function
REQ-014 SHALL implement states IDLE and COLLECT with a slot counter 0..MXCLUSTERS-1.
REQ-015 SHALL, in IDLE, ignore slot_valid without sof, with no output change.
REQ-016 SHALL, on slot_valid with sof, clear the accumulator and cluster count, process the slot as slot 0, and enter COLLECT.
REQ-017 SHALL, in COLLECT, advance the counter once per slot_valid cycle and hold it when slot_valid is low, allowing gaps of any length.
REQ-018 SHALL expand each slot with vpf_in=1 and adr_in<MXSTRIPS by OR-ing ones into strips adr_in..adr_in+cnt_in.
REQ-019 SHALL truncate strips beyond MXSTRIPS-1, with no wrap to strip 0.
REQ-020 SHALL ignore slots with vpf_in=0, or with adr_in>=MXSTRIPS, for both the map and ncl_out.
REQ-021 SHALL merge overlapping or duplicate clusters by OR, while ncl_out counts each accepted slot.
REQ-022 SHALL, on acceptance of slot MXCLUSTERS-1, on the next cycle copy the accumulator to vpfs_out, copy the count to ncl_out, pulse latch_out, and return to IDLE.
REQ-023 SHALL hold vpfs_out and ncl_out stable between latch_out pulses.
REQ-024 SHALL, on sof with slot_valid while in COLLECT, discard the partial frame, pulse abort_out on the next cycle, and restart per REQ-016 with that slot as slot 0.
REQ-025 SHALL accept back-to-back frames, with sof in the cycle after the last slot, at no lost slots.

Reset
REQ-026 SHALL, on reset, enter IDLE and clear the counter and accumulator.
REQ-027 SHALL, on reset, set vpfs_out=0, ncl_out=0, latch_out=0, and abort_out=0.
REQ-028 SHALL give reset priority over all inputs, and a reset mid-frame SHALL discard the frame with no abort_out pulse.

Configuration
REQ-029 SHALL, with macro CLUSTER_EXPANDER_BADADR_CNT_EN defined, add output bad_adr_cnt (out, 8 bits), counting slots with vpf_in=1 and adr_in>=MXSTRIPS; it saturates at 255 and is cleared only by reset.
REQ-030 SHALL, without CLUSTER_EXPANDER_BADADR_CNT_EN, omit the bad_adr_cnt port and counter entirely, with no other behaviour change.

Verification
REQ-031 SHALL verify one frame: slot0 adr=0 cnt=0 and slot1 adr=1535 cnt=7, others vpf=0 -> latch_out one cycle after slot7; vpfs_out bits 0 and 1535 set; ncl_out=2.
REQ-032 SHALL verify overlap: adr=10 cnt=3 and adr=12 cnt=3 -> bits 10..15 set; ncl_out=2.
REQ-033 SHALL verify gaps: 8 slots with slot_valid low 3 cycles between each -> single latch_out one cycle after the last slot; result equals the gapless run.
REQ-034 SHALL verify abort: sof at slot 4 of a frame -> abort_out pulse; a following complete frame emits only its own clusters.
REQ-035 SHALL verify bad address: vpf=1 adr=1600 -> ignored; ncl_out excludes it; with the macro, bad_adr_cnt=1; 300 such slots -> bad_adr_cnt=255.
REQ-036 SHALL verify reset mid-frame: reset at slot 3 -> all outputs 0, no latch_out or abort_out; the next sof frame emits normally.
